// File: rtl/pcnt_multi.sv
// pcnt_multi: NCH independent WIDTH-bit pulse counters for the pcnt tile.
// Each channel has edge selection, up/down counting, two compare values,
// an optional period-reload mode and wrap/underflow flagging. All
// configuration comes from the static config-memory bus mode_i.
//
// Per-channel config layout (base b = c*CFG_W):
//   [b +: WIDTH]          match0
//   [b+WIDTH +: WIDTH]    match1
//   [b+2*WIDTH +: 2]      edge_sel (00 off, 01 rise, 10 fall, 11 both)
//   [b+2*WIDTH+2]         reload_en
//   [b+2*WIDTH+3]         dir_invert
//
// No valid/ready handshakes: events are free-running levels and every
// output is a registered level or a one-cycle pulse.
module pcnt_multi #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int CFG_W = 2*WIDTH+4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH-1:0]         event_i,
  input  logic [NCH-1:0]         up_down_i,
  input  logic [NCH-1:0]         stop_i,
  input  logic [NCH*CFG_W-1:0]   mode_i,
  output logic [NCH*WIDTH-1:0]   count_o,
  output logic [NCH-1:0]         match0_o,
  output logic [NCH-1:0]         match1_o,
  output logic [NCH-1:0]         zero_o,
  output logic [NCH-1:0]         ovf_o
);

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};

  // Previous event level for edge detection, and the arming flag that
  // blocks counting on the first cycle after reset release.
  logic [NCH-1:0] event_q;
  logic           armed;

  // event_q tracks event_i continuously (even while stopped or disabled),
  // so releasing stop never counts an edge that happened while stopped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_q <= '0;
      armed   <= 1'b0;
    end else begin
      event_q <= event_i;
      armed   <= 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int B = c*CFG_W;

    logic [WIDTH-1:0] match0;
    logic [WIDTH-1:0] match1;
    logic [1:0]       edge_sel;
    logic             reload_en;
    logic             dir_invert;

    logic             rise;
    logic             fall;
    logic             edge_hit;
    logic             step;
    logic             dir_up;
    logic             wrap;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             match0_q;
    logic             match1_q;
    logic             zero_q;
    logic             ovf_q;

    assign match0     = mode_i[B +: WIDTH];
    assign match1     = mode_i[B+WIDTH +: WIDTH];
    assign edge_sel   = mode_i[B+2*WIDTH +: 2];
    assign reload_en  = mode_i[B+2*WIDTH+2];
    assign dir_invert = mode_i[B+2*WIDTH+3];

    // Qualify the selected edge and compute the next count and wrap flag.
    always_comb begin
      rise     = event_i[c] & ~event_q[c];
      fall     = ~event_i[c] & event_q[c];
      edge_hit = 1'b0;
      case (edge_sel)
        2'b01:   edge_hit = rise;
        2'b10:   edge_hit = fall;
        2'b11:   edge_hit = rise | fall;
        default: edge_hit = 1'b0;
      endcase
      step    = armed & ~stop_i[c] & edge_hit;
      dir_up  = up_down_i[c] ^ dir_invert;
      count_d = count_q;
      wrap    = 1'b0;
      if (step) begin
        if (dir_up) begin
          // Period reload takes priority so match1 == MAX reloads silently.
          if (reload_en && (count_q == match1)) begin
            count_d = '0;
          end else if (count_q == MAX_CNT) begin
            count_d = '0;
            wrap    = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = reload_en ? match1 : MAX_CNT;
            wrap    = 1'b1;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end

    // Register the count and flags; pulses only follow a qualified step.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        count_q  <= '0;
        match0_q <= 1'b0;
        match1_q <= 1'b0;
        zero_q   <= 1'b1;
        ovf_q    <= 1'b0;
      end else begin
        count_q  <= count_d;
        match0_q <= step && (count_d == match0);
        match1_q <= step && (count_d == match1);
        zero_q   <= (count_d == '0);
        ovf_q    <= step && wrap;
      end
    end

    assign count_o[c*WIDTH +: WIDTH] = count_q;
    assign match0_o[c] = match0_q;
    assign match1_o[c] = match1_q;
    assign zero_o[c]   = zero_q;
    assign ovf_o[c]    = ovf_q;
  end

endmodule

// File: tb/tb_pcnt_multi.sv
// Directed testbench for pcnt_multi (WIDTH = 16, NCH = 4).
module tb_pcnt_multi;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;
  localparam int CFG_W = 2*WIDTH+4;

  logic                 clk_i;
  logic                 rst_i;
  logic [NCH-1:0]       event_i;
  logic [NCH-1:0]       up_down_i;
  logic [NCH-1:0]       stop_i;
  logic [NCH*CFG_W-1:0] mode_i;
  logic [NCH*WIDTH-1:0] count_o;
  logic [NCH-1:0]       match0_o;
  logic [NCH-1:0]       match1_o;
  logic [NCH-1:0]       zero_o;
  logic [NCH-1:0]       ovf_o;

  int total  = 0;
  int passed = 0;

  pcnt_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .event_i   (event_i),
    .up_down_i (up_down_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .count_o   (count_o),
    .match0_o  (match0_o),
    .match1_o  (match1_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o)
  );

  // Clock generation.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_cfg(input int c, input logic [15:0] m0, input logic [15:0] m1,
                         input logic [1:0] es, input logic rel, input logic inv);
    mode_i[c*CFG_W +: CFG_W] = {inv, rel, es, m1, m0};
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] cnt(input int c);
    return count_o[c*WIDTH +: WIDTH];
  endfunction

  logic [15:0] exp_cnt [10];

  initial begin
    rst_i     = 1'b1;
    event_i   = 4'b0001;
    up_down_i = 4'b1111;
    stop_i    = 4'b0000;
    mode_i    = '0;
    set_cfg(0, 16'h0100, 16'h0200, 2'b01, 1'b0, 1'b0);
    set_cfg(1, 16'h0100, 16'h0200, 2'b00, 1'b0, 1'b0);
    set_cfg(2, 16'h0100, 16'h0200, 2'b00, 1'b0, 1'b0);
    set_cfg(3, 16'h0100, 16'h0200, 2'b00, 1'b0, 1'b0);

    // 1. Reset and arming with event held high.
    tick();
    tick();
    check("rst_count", count_o, 64'h0);
    check("rst_zero", zero_o, 4'b1111);
    check("rst_pulses", {match0_o, match1_o, ovf_o}, 12'h0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arm_count0", cnt(0), 16'h0);
      check("arm_zero0", zero_o[0], 1'b1);
      check("arm_pulses", {match0_o, match1_o, ovf_o}, 12'h0);
    end
    event_i[0] = 1'b0; tick();
    event_i[0] = 1'b1; tick();
    check("arm_first_rise", cnt(0), 16'd1);
    event_i[0] = 1'b0; tick();
    event_i[0] = 1'b1; tick();
    check("arm_second_rise", cnt(0), 16'd2);
    check("arm_zero_low", zero_o[0], 1'b0);

    // 2. Up counting with period reload (match1 = 4, match0 = 2).
    event_i = 4'b0000;
    do_reset();
    set_cfg(0, 16'd2, 16'd4, 2'b01, 1'b1, 1'b0);
    exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    for (int i = 0; i < 10; i++) begin
      event_i[0] = 1'b1; tick();
      check("reload_count", cnt(0), exp_cnt[i]);
      check("reload_m0", match0_o[0], exp_cnt[i] == 16'd2);
      check("reload_m1", match1_o[0], exp_cnt[i] == 16'd4);
      check("reload_ovf", ovf_o[0], 1'b0);
      event_i[0] = 1'b0; tick();
      check("reload_pulse_end", {match0_o[0], match1_o[0]}, 2'b00);
    end

    // 3. Down underflow without and with reload.
    set_cfg(0, 16'h0100, 16'd9, 2'b01, 1'b0, 1'b0);
    up_down_i[0] = 1'b0;
    event_i[0] = 1'b1; tick();
    check("uflow_count", cnt(0), 16'hFFFF);
    check("uflow_ovf", ovf_o[0], 1'b1);
    check("uflow_zero", zero_o[0], 1'b0);
    event_i[0] = 1'b0; tick();
    check("uflow_ovf_end", ovf_o[0], 1'b0);
    check("uflow_hold", cnt(0), 16'hFFFF);
    do_reset();
    set_cfg(0, 16'h0100, 16'd9, 2'b01, 1'b1, 1'b0);
    event_i[0] = 1'b1; tick();
    check("uflow_rl_count", cnt(0), 16'd9);
    check("uflow_rl_ovf", ovf_o[0], 1'b1);
    check("uflow_rl_m1", match1_o[0], 1'b1);
    event_i[0] = 1'b0; tick();
    check("uflow_rl_end", {ovf_o[0], match1_o[0]}, 2'b00);

    // 4. Both edges with dir_invert, then stop/release on channel 1.
    set_cfg(1, 16'h0100, 16'h0200, 2'b11, 1'b0, 1'b1);
    up_down_i[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      event_i[1] = ~event_i[1]; tick();
    end
    check("both_count", cnt(1), 16'd6);
    stop_i[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      event_i[1] = ~event_i[1]; tick();
      check("stop_hold", cnt(1), 16'd6);
    end
    stop_i[1] = 1'b0; tick();
    check("stop_release", cnt(1), 16'd6);
    event_i[1] = ~event_i[1]; tick();
    check("stop_next", cnt(1), 16'd7);

    // 5. Wrap at the top of the range on channel 2 (match0 = 0).
    set_cfg(2, 16'h0000, 16'h1234, 2'b01, 1'b0, 1'b0);
    up_down_i[2] = 1'b0;
    event_i[2] = 1'b1; tick();
    check("wrap_pre_ffff", cnt(2), 16'hFFFF);
    event_i[2] = 1'b0; tick();
    event_i[2] = 1'b1; tick();
    check("wrap_pre_fffe", cnt(2), 16'hFFFE);
    check("wrap_pre_ovf", ovf_o[2], 1'b0);
    event_i[2] = 1'b0; tick();
    up_down_i[2] = 1'b1;
    event_i[2] = 1'b1; tick();
    check("wrap_up_ffff", cnt(2), 16'hFFFF);
    check("wrap_up_ovf0", ovf_o[2], 1'b0);
    event_i[2] = 1'b0; tick();
    event_i[2] = 1'b1; tick();
    check("wrap_count", cnt(2), 16'h0000);
    check("wrap_ovf", ovf_o[2], 1'b1);
    check("wrap_zero", zero_o[2], 1'b1);
    check("wrap_m0", match0_o[2], 1'b1);
    event_i[2] = 1'b0; tick();
    check("wrap_ovf_end", ovf_o[2], 1'b0);

    // 6. Concurrent channels, then reset mid-stream.
    event_i = 4'b0000;
    stop_i  = 4'b0000;
    do_reset();
    set_cfg(0, 16'h0100, 16'h0200, 2'b01, 1'b0, 1'b0);
    set_cfg(1, 16'h0100, 16'h0200, 2'b11, 1'b0, 1'b0);
    set_cfg(2, 16'h0100, 16'd5,    2'b10, 1'b1, 1'b0);
    set_cfg(3, 16'h0100, 16'h0200, 2'b00, 1'b0, 1'b0);
    up_down_i = 4'b1011;
    event_i = 4'b1111; tick();
    event_i = 4'b0000; tick();
    check("multi_ch2_reload", cnt(2), 16'd5);
    check("multi_ovf", ovf_o, 4'b0100);
    event_i = 4'b1111; tick();
    event_i = 4'b0000; tick();
    event_i = 4'b1111; tick();
    check("multi_ch0", cnt(0), 16'd3);
    check("multi_ch1", cnt(1), 16'd5);
    check("multi_ch2", cnt(2), 16'd4);
    check("multi_ch3", cnt(3), 16'd0);
    check("multi_zero", zero_o, 4'b1000);
    rst_i = 1'b1;
    event_i = 4'b0000; tick();
    check("midrst_count", count_o, 64'h0);
    check("midrst_zero", zero_o, 4'b1111);
    check("midrst_pulses", {match0_o, match1_o, ovf_o}, 12'h0);
    rst_i = 1'b0;
    event_i = 4'b1111; tick();
    check("midrst_armed_count", count_o, 64'h0);
    check("midrst_armed_zero", zero_o, 4'b1111);
    event_i = 4'b0000; tick();
    check("post_ch0", cnt(0), 16'd0);
    check("post_ch1", cnt(1), 16'd1);
    check("post_ch2", cnt(2), 16'd5);
    check("post_ch3", cnt(3), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pcnt_multi.md
Name: pcnt_multi

Overview:
Next-generation pulse counter primitive for the pcnt logical tile. It provides NCH independent counters of WIDTH bits each. Every channel has configurable edge selection, up/down counting, two compare values, an optional period-reload mode, and wrap/underflow flagging. All configuration comes from the static config-memory bus `mode_i`, which is driven by CCFF memory.

Parameters:
- WIDTH, 16, counter and compare-value width per channel (2..32).
- NCH, 4, number of independent channels (1..8).
- CFG_W, 2*WIDTH+4, config bits per channel (derived; not to be overridden).

Ports:
- clk_i  in  1  fabric clock; all state on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- event_i  in  NCH  per-channel event input (level; edges counted).
- up_down_i  in  NCH  per-channel direction; 1 = up, 0 = down (before dir_invert).
- stop_i  in  NCH  per-channel hold; 1 = ignore events.
- mode_i  in  NCH*CFG_W  static configuration from config memory.
- count_o  out  NCH*WIDTH  registered counter values; channel c at [c*WIDTH +: WIDTH].
- match0_o  out  NCH  one-cycle pulse: count just became match0.
- match1_o  out  NCH  one-cycle pulse: count just became match1.
- zero_o  out  NCH  registered level: count == 0.
- ovf_o  out  NCH  one-cycle pulse on wrap or underflow.

Behaviour:
- Clock and reset: one clock, `clk_i`. Reset `rst_i` is synchronous and active-high.
- Per-channel config layout, with base b = c*CFG_W:
  - [b +: WIDTH] = match0
  - [b+WIDTH +: WIDTH] = match1
  - [b+2W +: 2] = edge_sel: 00 disabled, 01 rising, 10 falling, 11 both
  - [b+2W+2] = reload_en
  - [b+2W+3] = dir_invert
- Config changes take effect on the next clock edge. There is no shadowing.
- Reset values:
  - count = 0, zero_o = 1.
  - match0_o, match1_o, ovf_o = 0.
  - event_q = 0, armed = 0.
- Edge detection:
  - event_q <= event_i every cycle, including while stopped or disabled.
  - armed is set to 1 one cycle after reset deasserts.
  - While armed = 0, no edges are counted, so no spurious edge is seen at reset release.
  - Edge = selected transition between event_q and event_i, qualified by armed & ~stop_i & (edge_sel != 00).
- Direction: dir = up_down_i ^ dir_invert, sampled in the same cycle as the edge.
- Latency: event_i seen high at clock edge k (low at k-1) → count_o, flags and pulses updated at edge k. All outputs are registered, with no combinational paths.
- Next-count rules, per qualified edge:
  - Up, reload_en = 1 and count == match1 → 0; no ovf. Period is match1 + 1.
  - Up, count == 2^WIDTH-1 → 0; ovf_o pulse. This also applies when reload_en = 1 and count > match1 (e.g. after a config change).
  - Up, otherwise → count + 1.
  - Down, count == 0 → match1 if reload_en, else 2^WIDTH-1; ovf_o pulse in both cases.
  - Down, otherwise → count - 1.
- Flag rules:
  - match0_o / match1_o pulse for exactly one cycle when a qualified step lands on that value.
  - If match0 == match1, both pulse in the same cycle.
  - A reload or wrap landing on 0 pulses match0_o when match0 == 0.
  - No pulses without a qualified edge. Holding at a match value or reconfiguring onto the current count gives no pulse.
- zero_o: registered (next count == 0). It holds while stopped.
- stop_i: freezes count and suppresses pulses. Releasing stop does not count an edge that occurred while stopped, because event_q tracks continuously.
- Disabled channel (edge_sel = 00): behaves exactly like stop_i = 1.
- Reset mid-operation: every channel returns to reset values in the next cycle, including armed = 0. Reset overrides events.
- Channels are fully independent. There are no shared counters and no arbitration.

Test Plan:
1. Reset/arming: hold event_i = 1 through reset, release rst_i → count_o stays 0, zero_o = 1, no pulses for 3 cycles; then a 0→1→0→1 sequence (rising, WIDTH = 16) → count = 2 exactly one cycle after the second rise.
2. Up with reload: match1 = 4, match0 = 2, reload_en = 1, 10 rising edges → counts 1,2,3,4,0,1,2,3,4,0; match0_o pulses at counts 2 (twice); match1_o pulses at 4 (twice); ovf_o never asserts.
3. Down underflow: count = 0, reload_en = 0, direction down, one edge → count = 0xFFFF and ovf_o = 1 for one cycle; repeat with reload_en = 1, match1 = 9 → count = 9, ovf_o pulse, match1_o pulse.
4. Both-edge and dir_invert: edge_sel = 11, dir_invert = 1, up_down_i = 0, toggle event_i 6 times → count = 6; set stop_i = 1, toggle 3 times, release → count stays 6, and the next toggle gives 7.
5. Wrap: preload by counting to 0xFFFE (or use WIDTH = 4 to 14), 2 up edges with reload_en = 0 → 0xFFFF then 0, ovf_o pulse on the second, zero_o = 1.
6. Multi-channel and reset mid-run: NCH = 4 with distinct configs running concurrently → channel counts evolve independently. Assert rst_i for one cycle mid-stream → all count_o = 0, zero_o = 4'b1111 next cycle, and the first post-reset cycle counts nothing.
